// File: rtl/ddr_sdram_ex_pkg.sv
// ---------------------------------------------------------------------------
// ddr_sdram_ex_pkg
// Shared definitions for the DDR SDRAM example driver's pattern generator and
// read checker:
//   chk_state_t : checker FSM state encoding (IDLE, CHECK, DONE)
//   ERR_NONE    : first_err_beat value meaning "no mismatch seen"
//   CNT_MAX     : saturation value for 16-bit counters
//   lfsr_step() : one step of the per-byte-lane 8-bit LFSR. The write
//                 generator uses the same function, so both sides stay
//                 in lock-step.
// ---------------------------------------------------------------------------
package ddr_sdram_ex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } chk_state_t;

  localparam logic [15:0] ERR_NONE = 16'hFFFF;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  // Galois-style shift with taps at bits 2,3,4 (x^8+x^4+x^3+x^2+1),
  // maximal length: period 255 for any non-zero seed.
  function automatic logic [7:0] lfsr_step(input logic [7:0] d);
    logic [7:0] n;
    n[0] = d[7];
    n[1] = d[0];
    n[2] = d[1] ^ d[7];
    n[3] = d[2] ^ d[7];
    n[4] = d[3] ^ d[7];
    n[5] = d[4];
    n[6] = d[5];
    n[7] = d[6];
    return n;
  endfunction

endpackage

// File: rtl/ddr_sdram_ex_chk_lane.sv
// ---------------------------------------------------------------------------
// ddr_sdram_ex_chk_lane
// One byte lane of the read checker: holds the expected-value LFSR, compares
// it against the returned byte and keeps a sticky pass-not-fail bit.
// Ports:
//   clk, reset : clock, synchronous active-high reset (reloads the seed)
//   load_seed  : reload LFSR with LANE_SEED, clear pnf/mismatch state
//   step       : a valid beat is being checked this cycle
//   actual     : returned byte for this lane
//   mismatch   : registered; 1 on the cycle after a mismatching beat
//   pnf        : sticky pass-not-fail, 1 = lane clean
// ---------------------------------------------------------------------------
module ddr_sdram_ex_chk_lane
  import ddr_sdram_ex_pkg::*;
#(
  parameter logic [7:0] LANE_SEED = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_seed,
  input  logic       step,
  input  logic [7:0] actual,
  output logic       mismatch,
  output logic       pnf
);

  logic [7:0] lfsr_q, lfsr_d;
  logic       mismatch_q, mismatch_d;
  logic       pnf_q, pnf_d;
  logic       beat_bad;

  // Compare against the current expected value before it advances.
  assign beat_bad = step && (actual != lfsr_q);

  always_comb begin
    lfsr_d     = lfsr_q;
    mismatch_d = 1'b0;
    pnf_d      = pnf_q;
    if (load_seed) begin
      lfsr_d = LANE_SEED;
      pnf_d  = 1'b1;
    end else if (step) begin
      lfsr_d     = lfsr_step(lfsr_q);
      mismatch_d = beat_bad;
      if (beat_bad) begin
        pnf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q     <= LANE_SEED;
      mismatch_q <= 1'b0;
      pnf_q      <= 1'b1;
    end else begin
      lfsr_q     <= lfsr_d;
      mismatch_q <= mismatch_d;
      pnf_q      <= pnf_d;
    end
  end

  assign mismatch = mismatch_q;
  assign pnf      = pnf_q;

endmodule

// File: rtl/ddr_sdram_ex_lfsr_checker.sv
// ---------------------------------------------------------------------------
// ddr_sdram_ex_lfsr_checker
// Read-side checker for the DDR SDRAM example driver. Regenerates the
// per-lane LFSR write pattern and compares it beat by beat with read data.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start           : begin a run (honoured in IDLE/DONE only)
//   num_beats       : beats to check, latched on accepted start
//   rdata_valid     : rdata carries a valid beat
//   rdata           : read data, lane i = rdata[8i+7:8i]
//   busy            : high while checking
//   done            : high once the run has finished, held until next start
//   pass            : with done: no mismatch and no timeout
//   timed_out       : with done: run ended by idle timeout
//   pnf_per_byte    : sticky per-lane pass-not-fail
//   err_count       : beats with any lane mismatch, saturating
//   first_err_beat  : index of first mismatching beat, 0xFFFF if none
// Lane comparisons are registered, so the beat sampled at edge N is folded
// into err_count/first_err_beat at edge N+1, which is also when a finished
// run enters DONE.
// ---------------------------------------------------------------------------
module ddr_sdram_ex_lfsr_checker
  import ddr_sdram_ex_pkg::*;
#(
  parameter int NUM_BYTES = 2,
  parameter int SEED      = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            num_beats,
  input  logic                   rdata_valid,
  input  logic [8*NUM_BYTES-1:0] rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timed_out,
  output logic [NUM_BYTES-1:0]   pnf_per_byte,
  output logic [15:0]            err_count,
  output logic [15:0]            first_err_beat
);

  localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  chk_state_t       state_q, state_d;
  logic [15:0]      num_beats_q, num_beats_d;
  logic [15:0]      beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [15:0]      err_count_q, err_count_d;
  logic [15:0]      first_err_q, first_err_d;
  logic             pass_q, pass_d;
  logic             timed_out_q, timed_out_d;
  // Beat sampled on the previous edge whose lane results are now visible.
  logic             pend_q, pend_d;
  logic [15:0]      pend_beat_q, pend_beat_d;
  logic             pend_last_q, pend_last_d;

  logic                 load_seed;
  logic                 step;
  logic [NUM_BYTES-1:0] lane_mismatch;
  logic                 any_mismatch;
  logic [15:0]          err_upd;
  logic [15:0]          first_upd;

  // ---------------------------------------------------------------------
  // Byte lanes
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      ddr_sdram_ex_chk_lane #(
        .LANE_SEED(8'(SEED + gi))
      ) u_lane (
        .clk      (clk),
        .reset    (reset),
        .load_seed(load_seed),
        .step     (step),
        .actual   (rdata[8*gi +: 8]),
        .mismatch (lane_mismatch[gi]),
        .pnf      (pnf_per_byte[gi])
      );
    end
  endgenerate

  assign any_mismatch = |lane_mismatch;

  // Fold the pending beat's result into the error statistics. err_count
  // being zero is what marks "no mismatch yet", since it saturates rather
  // than wrapping back to zero.
  always_comb begin
    err_upd   = err_count_q;
    first_upd = first_err_q;
    if (pend_q && any_mismatch) begin
      if (err_count_q != CNT_MAX) begin
        err_upd = err_count_q + 16'd1;
      end
      if (err_count_q == 16'd0) begin
        first_upd = pend_beat_q;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM next-state and datapath
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    num_beats_d = num_beats_q;
    beat_cnt_d  = beat_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    timed_out_d = timed_out_q;
    pend_d      = 1'b0;
    pend_beat_d = pend_beat_q;
    pend_last_d = 1'b0;
    load_seed   = 1'b0;
    step        = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // rdata_valid is ignored here, including in the start cycle.
        if (start) begin
          num_beats_d = num_beats;
          load_seed   = 1'b1;
          beat_cnt_d  = 16'd0;
          idle_cnt_d  = '0;
          err_count_d = 16'd0;
          first_err_d = ERR_NONE;
          pass_d      = 1'b0;
          timed_out_d = 1'b0;
          if (num_beats == 16'd0) begin
            state_d = ST_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        err_count_d = err_upd;
        first_err_d = first_upd;
        if (pend_last_q) begin
          // Last beat's result has just been folded in; any beat arriving
          // in this cycle lies beyond the run and is not checked.
          state_d = ST_DONE;
          pass_d  = (err_upd == 16'd0);
        end else if (rdata_valid) begin
          step        = 1'b1;
          pend_d      = 1'b1;
          pend_beat_d = beat_cnt_q;
          pend_last_d = (beat_cnt_q == num_beats_q - 16'd1);
          beat_cnt_d  = beat_cnt_q + 16'd1;
          idle_cnt_d  = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d     = ST_DONE;
          timed_out_d = 1'b1;
          pass_d      = 1'b0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      num_beats_q <= 16'd0;
      beat_cnt_q  <= 16'd0;
      idle_cnt_q  <= '0;
      err_count_q <= 16'd0;
      first_err_q <= ERR_NONE;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_beat_q <= 16'd0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_beats_q <= num_beats_d;
      beat_cnt_q  <= beat_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
      timed_out_q <= timed_out_d;
      pend_q      <= pend_d;
      pend_beat_q <= pend_beat_d;
      pend_last_q <= pend_last_d;
    end
  end

  assign busy           = (state_q == ST_CHECK);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign timed_out      = timed_out_q;
  assign err_count      = err_count_q;
  assign first_err_beat = first_err_q;

endmodule

// File: tb/tb_ddr_sdram_ex_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_ddr_sdram_ex_lfsr_checker
// Directed bench for the LFSR read checker (NUM_BYTES=2, SEED=32,
// TIMEOUT=16). Expected lane bytes come from a GF(2^8) multiply-by-x model;
// a scoreboard derives run status from the beats sent, and one negedge
// process compares busy/done every cycle and the status outputs whenever the
// checker is not busy.
// ---------------------------------------------------------------------------
module tb_ddr_sdram_ex_lfsr_checker;

  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   num_beats = 16'd0;
  logic          rdata_valid = 1'b0;
  logic [15:0]   rdata = 16'd0;
  logic          busy, done, pass, timed_out;
  logic [NB-1:0] pnf_per_byte;
  logic [15:0]   err_count, first_err_beat;

  ddr_sdram_ex_lfsr_checker #(
    .NUM_BYTES(NB),
    .SEED     (32),
    .TIMEOUT  (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_beats     (num_beats),
    .rdata_valid   (rdata_valid),
    .rdata         (rdata),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timed_out     (timed_out),
    .pnf_per_byte  (pnf_per_byte),
    .err_count     (err_count),
    .first_err_beat(first_err_beat)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected lane byte for beat k: seed * x^k in GF(2^8) mod 0x11D.
  function automatic logic [7:0] model_byte(input logic [7:0] seed, input int k);
    logic [8:0] v;
    v = {1'b0, seed};
    for (int i = 0; i < (k % 255); i++) begin
      v = v << 1;
      if (v[8]) v = v ^ 9'h11D;
    end
    return v[7:0];
  endfunction

  function automatic logic [15:0] beat_data(input int k);
    return {model_byte(8'h21, k), model_byte(8'h20, k)};
  endfunction

  // Expected outputs
  logic          chk_en = 1'b0;
  logic          exp_busy = 1'b0, exp_done = 1'b0, exp_pass = 1'b0, exp_to = 1'b0;
  logic [NB-1:0] exp_pnf = '1;
  logic [15:0]   exp_err = 16'd0, exp_first = 16'hFFFF;

  // Scoreboard for the current run
  int            run_nb = 0;
  int            sent_cnt = 0;
  int            run_id = 0;
  int            sb_err = 0;
  logic [15:0]   sb_first = 16'hFFFF;
  logic [NB-1:0] sb_pnf = '1;
  logic          sb_to = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {15'd0, busy}, {15'd0, exp_busy});
      check("done", {15'd0, done}, {15'd0, exp_done});
      if (!exp_busy) begin
        check("pass", {15'd0, pass}, {15'd0, exp_pass});
        check("timed_out", {15'd0, timed_out}, {15'd0, exp_to});
        check("pnf_per_byte", {14'd0, pnf_per_byte}, {14'd0, exp_pnf});
        check("err_count", err_count, exp_err);
        check("first_err_beat", first_err_beat, exp_first);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reset_exp();
    exp_busy = 1'b0; exp_done = 1'b0; exp_pass = 1'b0; exp_to = 1'b0;
    exp_pnf = '1; exp_err = 16'd0; exp_first = 16'hFFFF;
  endtask

  task automatic finalize();
    exp_busy  = 1'b0;
    exp_done  = 1'b1;
    exp_to    = sb_to;
    exp_pass  = (sb_err == 0) && !sb_to;
    exp_pnf   = sb_pnf;
    exp_err   = (sb_err > 65535) ? 16'hFFFF : 16'(sb_err);
    exp_first = sb_first;
    $display("run %0d: beats=%0d sent=%0d exp_pass=%0b exp_err=%0d exp_first=%0h exp_to=%0b",
             run_id, run_nb, sent_cnt, exp_pass, exp_err, exp_first, exp_to);
  endtask

  // with_valid drives a junk beat in the start cycle, which must be ignored.
  task automatic do_start(input logic [15:0] nb, input logic with_valid);
    start = 1'b1; num_beats = nb; rdata_valid = with_valid; rdata = 16'hDEAD;
    tick();
    start = 1'b0; rdata_valid = 1'b0;
    run_id++;
    run_nb = int'(nb); sent_cnt = 0; sb_err = 0; sb_first = 16'hFFFF;
    sb_pnf = '1; sb_to = 1'b0;
    if (nb == 16'd0) begin
      finalize();
    end else begin
      exp_busy = 1'b1; exp_done = 1'b0;
    end
  endtask

  task automatic score(input logic [15:0] d);
    logic [NB-1:0] mism;
    for (int i = 0; i < NB; i++) begin
      mism[i] = (d[8*i +: 8] != model_byte(8'(32 + i), sent_cnt));
    end
    if (mism != '0) begin
      sb_err++;
      if (sb_first == 16'hFFFF) sb_first = 16'(sent_cnt);
    end
    sb_pnf = sb_pnf & ~mism;
    sent_cnt++;
  endtask

  // gap idle cycles precede the beat; start_in_gap pulses start while checking.
  task automatic send_beat(input logic [15:0] d, input int gap, input logic start_in_gap);
    for (int g = 0; g < gap; g++) begin
      rdata_valid = 1'b0;
      start = start_in_gap; num_beats = 16'd5;
      tick();
    end
    start = 1'b0;
    rdata_valid = 1'b1; rdata = d;
    tick();
    rdata_valid = 1'b0;
    score(d);
    if (sent_cnt == run_nb) begin
      tick();
      finalize();
    end
  endtask

  logic [15:0] t1 [4];

  initial begin
    t1[0] = 16'h2120; t1[1] = 16'h4240; t1[2] = 16'h8480; t1[3] = 16'h151D;

    // Model pins against hand-computed values
    check("pin_l0_k1", {8'd0, model_byte(8'h20, 1)}, 16'h0040);
    check("pin_l0_k3", {8'd0, model_byte(8'h20, 3)}, 16'h001D);
    check("pin_l1_k3", {8'd0, model_byte(8'h21, 3)}, 16'h0015);
    check("pin_l0_k255", {8'd0, model_byte(8'h20, 255)}, 16'h0020);
    check("pin_beat2", beat_data(2), 16'h8480);

    // Reset
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    set_reset_exp();
    chk_en = 1'b1;
    tick();

    // 1: clean 4-beat run from literal table; start cycle carries junk valid
    do_start(16'd4, 1'b1);
    for (int k = 0; k < 4; k++) send_beat(t1[k], 0, 1'b0);
    // valid beats in DONE are ignored
    rdata_valid = 1'b1; rdata = 16'h0000;
    tick(); tick(); tick();
    rdata_valid = 1'b0;

    // 2: beat 2 lane1 corrupted
    do_start(16'd4, 1'b0);
    for (int k = 0; k < 4; k++) send_beat((k == 2) ? 16'h8580 : t1[k], 0, 1'b0);
    tick();

    // 3: valid every 3rd cycle over 8 beats, start pulsed while checking
    do_start(16'd8, 1'b0);
    for (int k = 0; k < 8; k++) send_beat(beat_data(k), 2, (k == 3));
    tick();

    // 4: timeout after 2 of 4 beats
    do_start(16'd4, 1'b0);
    send_beat(beat_data(0), 0, 1'b0);
    send_beat(beat_data(1), 0, 1'b0);
    for (int c = 0; c < 15; c++) tick();
    tick();
    sb_to = 1'b1;
    finalize();
    tick();

    // 5: reset during beat 3 of 10, then a fresh clean run
    do_start(16'd10, 1'b0);
    send_beat(beat_data(0), 0, 1'b0);
    send_beat(beat_data(1), 0, 1'b0);
    rdata_valid = 1'b1; rdata = beat_data(2); reset = 1'b1;
    tick();
    reset = 1'b0; rdata_valid = 1'b0;
    set_reset_exp();
    $display("run %0d: reset applied mid-run", run_id);
    tick();
    do_start(16'd10, 1'b0);
    for (int k = 0; k < 10; k++) send_beat(beat_data(k), 0, 1'b0);
    tick();

    // 6: zero-beat run, then a 300-beat run wrapping the LFSR
    do_start(16'd0, 1'b0);
    tick();
    do_start(16'd300, 1'b0);
    for (int k = 0; k < 300; k++) send_beat(beat_data(k), 0, 1'b0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
